// File: rtl/reg_file_banked_if.sv
// reg_file_banked_if: bus bundle for reg_file_banked.
// Carries both write ports, the packed read-address/read-data ports and the
// save/restore handshake. master = core side (decode/writeback), slave = register file.
interface reg_file_banked_if #(
   parameter int W  = 8,
   parameter int D  = 3,
   parameter int NR = 2
);
   logic            we0;
   logic [D-1:0]    wa0;
   logic [W-1:0]    wd0;
   logic            we1;
   logic [D-1:0]    wa1;
   logic [W-1:0]    wd1;
   logic [NR*D-1:0] ra;
   logic [NR*W-1:0] rd;
   logic            save_req;
   logic            restore_req;
   logic            busy;
   logic            done;

   modport master (
      output we0, wa0, wd0, we1, wa1, wd1, ra, save_req, restore_req,
      input  rd, busy, done
   );

   modport slave (
      input  we0, wa0, wd0, we1, wa1, wd1, ra, save_req, restore_req,
      output rd, busy, done
   );
endinterface

// File: rtl/reg_file_banked.sv
// reg_file_banked: 2**D x W register file, NR combinational read ports, two
// clocked write ports (port 1 has priority), plus a whole-file shadow bank
// copied one register per cycle by a SAVE / RESTORE sequencer.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read
// forwarding (restore copy > write port 1 > write port 0 > stored value).
module reg_file_banked #(
   parameter int W  = 8,
   parameter int D  = 3,
   parameter int NR = 2
) (
   input logic              clk,
   input logic              rst_n,
   reg_file_banked_if.slave bus
);
   localparam int DEPTH = 1 << D;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SAVE    = 2'd1;
   localparam logic [1:0] ST_RESTORE = 2'd2;

   // idx is one bit wider than an address so the final increment never wraps
   localparam logic [D:0] LAST_IDX = {1'b0, {D{1'b1}}};
   localparam logic [D:0] IDX_ONE  = {{D{1'b0}}, 1'b1};

   logic [W-1:0] regs_q   [DEPTH];
   logic [W-1:0] regs_d   [DEPTH];
   logic [W-1:0] shadow_q [DEPTH];
   logic [W-1:0] shadow_d [DEPTH];
   logic [1:0]   state_q, state_d;
   logic [D:0]   idx_q, idx_d;
   logic         done_q, done_d;
   logic [D-1:0] cp_addr;

   assign cp_addr = idx_q[D-1:0];

   // Sequencer: start on request from IDLE (SAVE beats RESTORE), walk idx 0..2**D-1
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.save_req) begin
               state_d = ST_SAVE;
               idx_d   = '0;
            end else if (bus.restore_req) begin
               state_d = ST_RESTORE;
               idx_d   = '0;
            end
         end
         ST_SAVE, ST_RESTORE: begin
            idx_d = idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Main file next state: port 0, then port 1 overrides, then restore copy overrides both
   always_comb begin
      regs_d = regs_q;
      if (bus.we0) regs_d[bus.wa0] = bus.wd0;
      if (bus.we1) regs_d[bus.wa1] = bus.wd1;
      if (state_q == ST_RESTORE) regs_d[cp_addr] = shadow_q[cp_addr];
   end

   // Shadow next state: SAVE captures the pre-edge main value, ignoring same-cycle writes
   always_comb begin
      shadow_d = shadow_q;
      if (state_q == ST_SAVE) shadow_d[cp_addr] = regs_q[cp_addr];
   end

   // State registers; reset clears both banks and abandons any sequence in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         regs_q   <= regs_d;
         shadow_q <= shadow_d;
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;

   genvar gi;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_rd
         logic [D-1:0] ra_i;
         logic [W-1:0] rd_i;

         assign ra_i = bus.ra[gi*D +: D];

         // Read port: stored value, optionally forwarded from this cycle's writes
         always_comb begin
            rd_i = regs_q[ra_i];
`ifdef REGFILE_BYPASS_EN
            if (bus.we0 && (bus.wa0 == ra_i)) rd_i = bus.wd0;
            if (bus.we1 && (bus.wa1 == ra_i)) rd_i = bus.wd1;
            if ((state_q == ST_RESTORE) && (cp_addr == ra_i)) rd_i = shadow_q[cp_addr];
`endif
         end

         assign bus.rd[gi*W +: W] = rd_i;
      end
   endgenerate
endmodule
